// File: rtl/laser_rx_ftdi_writer.sv
// Laser-link receive path: deserializes framed bits into bytes, buffers them, writes to FT232H via TXE#/WR#.
// Latency: byte pushed 1 cycle after stop sample; write starts 1 cycle after FIFO goes non-empty (txe=0).
// Backpressure: txe high holds bytes in the FIFO; when full, new bytes are dropped and overflow sticks.
module laser_rx_ftdi_writer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int WR_SETUP     = 2,
  parameter int WR_PULSE     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          laser_rx,
  input  logic                          txe,
  output logic [7:0]                    adbus_out,
  output logic                          adbus_tri,
  output logic                          ftdi_wr,
  output logic [7:0]                    rx_byte,
  output logic                          byte_valid,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BTW = $clog2(CLKS_PER_BIT);
  localparam int WTW = $clog2(WR_SETUP + WR_PULSE + 1);

  localparam logic [BTW-1:0] HALF_LAST  = BTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BTW-1:0] BIT_LAST   = BTW'(CLKS_PER_BIT - 1);
  localparam logic [WTW-1:0] SETUP_LAST = WTW'(WR_SETUP - 1);
  localparam logic [WTW-1:0] PULSE_LAST = WTW'(WR_PULSE - 1);
  localparam logic [AW:0]    FULL_COUNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} wr_state_t;

  // rx_prev gives the synchronized 0->1 edge that starts a frame
  logic rx_meta, rx_sync, rx_prev, rx_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= laser_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_rise = rx_sync & ~rx_prev;

  rx_state_t      rx_state;
  logic [BTW-1:0] bit_timer;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           push_pend;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= R_IDLE;
      bit_timer  <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      push_pend  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      push_pend  <= 1'b0;
      if (!en) begin
        rx_state  <= R_IDLE;
        bit_timer <= '0;
        bit_idx   <= '0;
        shreg     <= '0;
      end else begin
        case (rx_state)
          R_IDLE: begin
            if (rx_rise) begin
              rx_state  <= R_START;
              bit_timer <= '0;
            end
          end
          R_START: begin
            if (bit_timer == HALF_LAST) begin
              bit_timer <= '0;
              bit_idx   <= '0;
              rx_state  <= rx_sync ? R_DATA : R_IDLE;
            end else begin
              bit_timer <= bit_timer + 1'b1;
            end
          end
          R_DATA: begin
            if (bit_timer == BIT_LAST) begin
              bit_timer <= '0;
              shreg     <= {rx_sync, shreg[7:1]};
              bit_idx   <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) rx_state <= R_STOP;
            end else begin
              bit_timer <= bit_timer + 1'b1;
            end
          end
          R_STOP: begin
            if (bit_timer == BIT_LAST) begin
              bit_timer <= '0;
              rx_state  <= R_IDLE;
              if (!rx_sync) begin
                rx_byte    <= shreg;
                byte_valid <= 1'b1;
                push_pend  <= 1'b1;
              end else begin
                frame_err  <= 1'b1;
              end
            end else begin
              bit_timer <= bit_timer + 1'b1;
            end
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty, push_ok, pop;
  wr_state_t     wr_state;

  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);
  assign pop        = (wr_state == W_HOLD);
  // a pop in the same cycle frees the slot, so a push onto a full FIFO still lands
  assign push_ok    = push_pend && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_pend && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  logic [WTW-1:0] wr_timer;

  // adbus_tri is dropped from W_IDLE, so the bus stays driven through the first idle cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_state  <= W_IDLE;
      wr_timer  <= '0;
      adbus_out <= '0;
      adbus_tri <= 1'b0;
      ftdi_wr   <= 1'b1;
    end else begin
      case (wr_state)
        W_IDLE: begin
          ftdi_wr <= 1'b1;
          if (en && !fifo_empty && !txe) begin
            wr_state  <= W_SETUP;
            wr_timer  <= '0;
            adbus_out <= mem[rd_ptr];
            adbus_tri <= 1'b1;
          end else begin
            adbus_tri <= 1'b0;
          end
        end
        W_SETUP: begin
          if (wr_timer == SETUP_LAST) begin
            wr_state <= W_STROBE;
            wr_timer <= '0;
            ftdi_wr  <= 1'b0;
          end else begin
            wr_timer <= wr_timer + 1'b1;
          end
        end
        W_STROBE: begin
          if (wr_timer == PULSE_LAST) begin
            wr_state <= W_HOLD;
            wr_timer <= '0;
            ftdi_wr  <= 1'b1;
          end else begin
            wr_timer <= wr_timer + 1'b1;
          end
        end
        W_HOLD: begin
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_rx_ftdi_writer.sv
// Directed bench for laser_rx_ftdi_writer: frame table plus hand sequences for write timing and reset.
module tb_laser_rx_ftdi_writer;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset_n, en, laser_rx, txe;
  logic [7:0] adbus_out, rx_byte;
  logic       adbus_tri, ftdi_wr, byte_valid, frame_err, overflow;
  logic [4:0] fifo_count;

  laser_rx_ftdi_writer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .WR_SETUP(2), .WR_PULSE(4)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .laser_rx(laser_rx), .txe(txe),
    .adbus_out(adbus_out), .adbus_tri(adbus_tri), .ftdi_wr(ftdi_wr), .rx_byte(rx_byte),
    .byte_valid(byte_valid), .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bus monitor, sampled on the falling edge
  logic [7:0] wr_q[$];
  int nvalid = 0, nerr = 0, proto_bad = 0;
  int tri_len = 0, wr_len = 0, setup_cnt = 0;
  int last_tri_len = 0, last_wr_len = 0, last_setup_len = 0;
  logic prev_tri = 1'b0, prev_wr = 1'b1;
  logic [7:0] prev_out = 8'h00;

  always @(negedge clock) begin
    if (!reset_n) begin
      tri_len = 0; wr_len = 0; setup_cnt = 0;
      prev_tri = 1'b0; prev_wr = 1'b1;
    end else begin
      if (byte_valid) nvalid++;
      if (frame_err) nerr++;
      if (adbus_tri) tri_len++;
      else if (prev_tri) begin last_tri_len = tri_len; tri_len = 0; end
      if (!ftdi_wr) begin
        if (!adbus_tri) proto_bad++;
        if (!prev_wr && adbus_out != prev_out) proto_bad++;
        if (prev_wr) begin wr_q.push_back(adbus_out); last_setup_len = setup_cnt; end
        wr_len++;
      end else if (!prev_wr) begin
        last_wr_len = wr_len; wr_len = 0;
      end
      if (adbus_tri && ftdi_wr) setup_cnt++; else setup_cnt = 0;
      prev_tri = adbus_tri; prev_wr = ftdi_wr; prev_out = adbus_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    laser_rx = 1'b1; tick(CPB);
    for (int b = 0; b < 8; b++) begin laser_rx = d[b]; tick(CPB); end
    laser_rx = stop; tick(CPB);
    laser_rx = 1'b0; tick(CPB);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((fifo_count != 0 || adbus_tri) && n < 500) begin tick(1); n++; end
    check(name, int'(n < 500), 1);
    tick(4);
  endtask

  task automatic wait_wr_low(input string name);
    int n = 0;
    while (ftdi_wr && n < 200) begin tick(1); n++; end
    check(name, int'(n < 200), 1);
  endtask

  task automatic check_single(input string name);
    check({name, "_wr_len"}, last_wr_len, 4);
    check({name, "_setup"}, last_setup_len, 2);
    check({name, "_tri_len"}, last_tri_len, 8);
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    int         exp_count;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] exp_q[$];

  initial begin
    int v0, e0, q0;
    vecs[0] = '{8'h01, 1'b0, 1, 0, 1, 8'h01};
    vecs[1] = '{8'h02, 1'b0, 1, 0, 2, 8'h02};
    vecs[2] = '{8'h03, 1'b0, 1, 0, 3, 8'h03};
    vecs[3] = '{8'h3C, 1'b1, 0, 1, 3, 8'h03};
    vecs[4] = '{8'hFF, 1'b0, 1, 0, 4, 8'hFF};
    vecs[5] = '{8'h00, 1'b0, 1, 0, 5, 8'h00};

    reset_n = 1'b0; en = 1'b0; txe = 1'b1; laser_rx = 1'b0;
    tick(3);
    check("rst_adbus_out", int'(adbus_out), 0);
    check("rst_adbus_tri", int'(adbus_tri), 0);
    check("rst_ftdi_wr", int'(ftdi_wr), 1);
    check("rst_rx_byte", int'(rx_byte), 0);
    check("rst_byte_valid", int'(byte_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    reset_n = 1'b1; en = 1'b1;
    tick(3);

    // single byte straight through
    txe = 1'b0;
    send_frame(8'hA5, 1'b0);
    wait_drain("a5_drain");
    check("a5_valid", nvalid, 1);
    check("a5_rx_byte", int'(rx_byte), 8'hA5);
    check("a5_writes", wr_q.size(), 1);
    check("a5_data", int'(wr_q[0]), 8'hA5);
    check_single("a5");

    // frame table under back-pressure
    txe = 1'b1;
    q0 = wr_q.size();
    foreach (vecs[i]) begin
      v0 = nvalid; e0 = nerr;
      send_frame(vecs[i].dat, vecs[i].stop);
      check($sformatf("vec%0d_valid", i), nvalid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_err", i), nerr - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_count", i), int'(fifo_count), vecs[i].exp_count);
      check($sformatf("vec%0d_rx", i), int'(rx_byte), int'(vecs[i].exp_rx));
      if (vecs[i].stop == 1'b0) exp_q.push_back(vecs[i].dat);
    end
    check("bp_no_write", wr_q.size(), q0);
    check("bp_wr_high", int'(ftdi_wr), 1);
    txe = 1'b0;
    wait_drain("bp_drain");
    check("bp_writes", wr_q.size() - q0, exp_q.size());
    foreach (exp_q[i]) check($sformatf("bp_data%0d", i), int'(wr_q[q0 + i]), int'(exp_q[i]));
    check("bp_count", int'(fifo_count), 0);

    // short glitch is not a start bit
    v0 = nvalid; e0 = nerr;
    laser_rx = 1'b1; tick(5); laser_rx = 1'b0; tick(40);
    check("glitch_valid", nvalid - v0, 0);
    check("glitch_err", nerr - e0, 0);
    check("glitch_count", int'(fifo_count), 0);

    // overflow: 17 bytes into 16 slots
    txe = 1'b1;
    v0 = nvalid;
    for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b0);
    check("ovf_count", int'(fifo_count), 16);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_valid", nvalid - v0, 17);
    check("ovf_rx_byte", int'(rx_byte), 8'h20);
    q0 = wr_q.size();
    txe = 1'b0;
    wait_drain("ovf_drain");
    check("ovf_writes", wr_q.size() - q0, 16);
    for (int i = 0; i < 16; i++) check($sformatf("ovf_data%0d", i), int'(wr_q[q0 + i]), 8'h10 + i);

    // txe rises mid-strobe: pulse completes, next byte waits
    txe = 1'b1;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    check("txe_count2", int'(fifo_count), 2);
    q0 = wr_q.size();
    txe = 1'b0;
    wait_wr_low("txe_wr_low");
    txe = 1'b1;
    tick(20);
    check("txe_wr_len", last_wr_len, 4);
    check("txe_one_write", wr_q.size() - q0, 1);
    check("txe_first", int'(wr_q[q0]), 8'h11);
    check("txe_count1", int'(fifo_count), 1);
    check("txe_tri_idle", int'(adbus_tri), 0);
    txe = 1'b0;
    wait_drain("txe_drain");
    check("txe_second", int'(wr_q[q0 + 1]), 8'h22);
    check_single("txe_b22");

    // reset while receiving data bits and strobing WR#
    txe = 1'b1;
    send_frame(8'h77, 1'b0);
    laser_rx = 1'b1; tick(CPB);
    laser_rx = 1'b1; tick(10);
    txe = 1'b0;
    wait_wr_low("rst_wr_low");
    tick(1);
    reset_n = 1'b0;
    #2;
    check("midrst_ftdi_wr", int'(ftdi_wr), 1);
    check("midrst_adbus_tri", int'(adbus_tri), 0);
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_overflow", int'(overflow), 0);
    check("midrst_rx_byte", int'(rx_byte), 0);
    laser_rx = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    q0 = wr_q.size();
    v0 = nvalid;
    send_frame(8'h5A, 1'b0);
    wait_drain("post_drain");
    check("post_valid", nvalid - v0, 1);
    check("post_rx_byte", int'(rx_byte), 8'h5A);
    check("post_writes", wr_q.size() - q0, 1);
    check("post_data", int'(wr_q[wr_q.size() - 1]), 8'h5A);
    check_single("post");

    check("protocol", proto_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/laser_rx_ftdi_writer.md
Name: laser_rx_ftdi_writer

Overview:
- Receive path of the laser link. Deserializes the framed bitstream arriving on the laser receiver input into bytes.
- Buffers the bytes in a small FIFO and writes them to the host through the FT232H 245-style FIFO interface using the TXE#/WR# write handshake.
- Sits beside the existing host-read/laser-transmit path and shares the ADBUS tristate control with it.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per laser bit; even, at least 4.
- FIFO_DEPTH, 16: byte FIFO entries; power of 2.
- WR_SETUP, 2: cycles ADBUS data is driven before WR# falls.
- WR_PULSE, 4: cycles WR# is held low.

Ports:
- clock, input, 1: system clock (50 MHz).
- reset_n, input, 1: asynchronous, active-low reset.
- en, input, 1: receive/write enable.
- laser_rx, input, 1: raw laser receiver line (asynchronous).
- txe, input, 1: FTDI TXE#, active-low; 0 means the FTDI can accept a byte.
- adbus_out, output, 8: data driven onto ADBUS.
- adbus_tri, output, 1: 1 means the FPGA drives ADBUS; 0 means ADBUS is high-Z.
- ftdi_wr, output, 1: FTDI WR#, active-low.
- rx_byte, output, 8: last byte accepted into the FIFO (for HEX display).
- byte_valid, output, 1: one-cycle pulse per accepted byte.
- frame_err, output, 1: one-cycle pulse per bad stop bit.
- overflow, output, 1: sticky flag; set when a byte is dropped because the FIFO is full.
- fifo_count, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset values:
  - adbus_out = 0, adbus_tri = 0, ftdi_wr = 1, rx_byte = 0.
  - byte_valid = 0, frame_err = 0, overflow = 0, fifo_count = 0.
  - Both FSMs in IDLE. Synchronizer flops reset to 0.
- laser_rx passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Frame format: line idles 0 (laser off); start bit = 1; 8 data bits, LSB first; stop bit = 0.
- RX FSM:
  - R_IDLE: on a synchronized 0→1 transition with en=1, go to R_START and clear the bit timer.
  - R_START: at CLKS_PER_BIT/2 cycles, if the line is 1 go to R_DATA, else back to R_IDLE (glitch, no error).
  - R_DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift into bit[i]. After bit 7 go to R_STOP.
  - R_STOP: sample at mid-bit.
    - If 0: push the byte, update rx_byte, pulse byte_valid the next cycle.
    - If 1: discard the byte and pulse frame_err.
    - Either way return to R_IDLE. A new start may be detected from the next cycle on; a line still at 1 requires a fresh 0→1 edge.
  - en=0 at any point forces R_IDLE and discards any partial byte.
- FIFO:
  - Push when a byte is accepted.
  - If full on a push: drop the byte, set overflow; rx_byte and byte_valid still update.
  - Simultaneous push and pop on a full FIFO is legal: the pop frees a slot, so the push succeeds.
  - Pop only at the end of W_HOLD.
  - Pointers wrap modulo FIFO_DEPTH.
- Write FSM:
  - W_IDLE: adbus_tri = 0, ftdi_wr = 1. Start when en=1, FIFO not empty and txe=0 → W_SETUP, latching the FIFO head into adbus_out.
  - W_SETUP: adbus_tri = 1, ftdi_wr = 1 for WR_SETUP cycles, then W_STROBE.
  - W_STROBE: ftdi_wr = 0 for WR_PULSE cycles, then W_HOLD.
  - W_HOLD: ftdi_wr = 1, adbus_tri = 1 for 1 cycle, then pop and go to W_IDLE.
  - adbus_tri deasserts on the cycle after W_HOLD.
  - Total per byte: WR_SETUP + WR_PULSE + 2 cycles minimum, including the return to W_IDLE.
- Once W_SETUP is entered the transfer always completes, even if txe rises or en falls. txe is re-checked only in W_IDLE.
- Latency: byte push occurs 1 cycle after the stop-bit sample. W_SETUP is entered 1 cycle after the FIFO becomes non-empty, provided txe=0.
- Reset mid-frame or mid-write: all outputs return to reset values immediately (asynchronously); ftdi_wr goes high and ADBUS is released.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=16, WR_SETUP=2, WR_PULSE=4):
- Single byte: send frame 0xA5 with txe=0 → byte_valid pulse, rx_byte=0xA5. adbus_tri high 8 cycles with adbus_out=0xA5. ftdi_wr low exactly 4 cycles, starting 2 cycles after adbus_tri rises.
- Back-pressure: txe=1 while sending 3 frames (0x01, 0x02, 0x03) → fifo_count=3, ftdi_wr stays 1. Release txe → three WR# pulses in order 0x01, 0x02, 0x03; fifo_count returns to 0.
- Glitch and framing: a 5-cycle 1-pulse on laser_rx → no byte, no error. A frame 0x3C with stop bit 1 → frame_err pulse, fifo_count unchanged.
- Overflow: txe=1, send 17 frames → fifo_count=16, overflow=1, and the 17th byte never appears on ADBUS after txe=0.
- txe rises during W_STROBE → the WR# pulse still completes its 4 cycles; the next byte waits in W_IDLE until txe=0.
- Reset: assert reset_n=0 mid-R_DATA and mid-W_STROBE → ftdi_wr=1 and adbus_tri=0 immediately. After release, a clean frame 0x5A is received and written correctly.
